// File: rtl/riscy_mem_port_arbiter.sv
// Shares one OBI-style memory port between the instruction-fetch and data-LSU ports.
// Holds the selected requester until the grant arrives and routes in-order responses back to the issuing port.
module riscy_mem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter bit          RR_EN           = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    instr_req_i,
   input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
   output logic                    instr_gnt_o,
   output logic                    instr_rvalid_o,
   output logic [DATA_WIDTH-1:0]   instr_rdata_o,
   input  logic                    data_req_i,
   input  logic                    data_we_i,
   input  logic [DATA_WIDTH/8-1:0] data_be_i,
   input  logic [ADDR_WIDTH-1:0]   data_addr_i,
   input  logic [DATA_WIDTH-1:0]   data_wdata_i,
   output logic                    data_gnt_o,
   output logic                    data_rvalid_o,
   output logic [DATA_WIDTH-1:0]   data_rdata_o,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic                    mem_gnt_i,
   input  logic                    mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   output logic                    spurious_o,
   output logic                    busy_o
);

   localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
   localparam int unsigned PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic {IDLE = 1'b0, WAIT_GNT = 1'b1} state_e;
   typedef enum logic {OWN_INSTR = 1'b0, OWN_DATA = 1'b1} owner_e;

   state_e                 state_q;
   owner_e                 lock_q;
   owner_e                 last_owner_q;
   owner_e                 order_q [MAX_OUTSTANDING];
   logic [PTR_WIDTH-1:0]   wr_ptr_q;
   logic [PTR_WIDTH-1:0]   rd_ptr_q;
   logic [CNT_WIDTH-1:0]   count_q;

   owner_e                 owner;
   owner_e                 head;
   logic                   full;
   logic                   empty;
   logic                   req_c;
   logic                   grant;
   logic                   pop;

   function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
      return (p == PTR_WIDTH'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_WIDTH'(1);
   endfunction

   // Owner selection: a locked owner always wins, otherwise resolve ties by RR or fixed priority
   always_comb begin
      owner = OWN_INSTR;
      if (state_q == WAIT_GNT) begin
         owner = lock_q;
      end else if (instr_req_i && data_req_i) begin
         if (RR_EN) owner = (last_owner_q == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
         else       owner = OWN_DATA;
      end else if (data_req_i) begin
         owner = OWN_DATA;
      end
   end

   assign full  = (count_q == CNT_WIDTH'(MAX_OUTSTANDING));
   assign empty = (count_q == '0);
   assign req_c = !full && ((state_q == WAIT_GNT) || instr_req_i || data_req_i);
   assign grant = req_c && mem_gnt_i;
   assign pop   = mem_rvalid_i && !empty;
   assign head  = order_q[rd_ptr_q];

   // Request channel fields; every output is held at zero while reset is asserted
   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      instr_gnt_o = 1'b0;
      data_gnt_o  = 1'b0;
      if (rst_ni) begin
         mem_req_o = req_c;
         if (owner == OWN_DATA) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
         end else begin
            mem_be_o    = {BE_WIDTH{1'b1}};
            mem_addr_o  = instr_addr_i;
         end
         instr_gnt_o = grant && (owner == OWN_INSTR);
         data_gnt_o  = grant && (owner == OWN_DATA);
      end
   end

   // Response channel: rdata is broadcast, rvalid goes only to the port at the FIFO head
   always_comb begin
      instr_rvalid_o = 1'b0;
      data_rvalid_o  = 1'b0;
      instr_rdata_o  = '0;
      data_rdata_o   = '0;
      spurious_o     = 1'b0;
      busy_o         = 1'b0;
      if (rst_ni) begin
         instr_rvalid_o = pop && (head == OWN_INSTR);
         data_rvalid_o  = pop && (head == OWN_DATA);
         instr_rdata_o  = mem_rdata_i;
         data_rdata_o   = mem_rdata_i;
         spurious_o     = mem_rvalid_i && empty;
         busy_o         = !empty || (state_q == WAIT_GNT);
      end
   end

   // Lock FSM, round-robin history and in-order owner FIFO
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         lock_q       <= OWN_INSTR;
         last_owner_q <= OWN_INSTR;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         for (int i = 0; i < int'(MAX_OUTSTANDING); i++) order_q[i] <= OWN_INSTR;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_c && !mem_gnt_i) begin
                  state_q <= WAIT_GNT;
                  lock_q  <= owner;
               end
            end
            WAIT_GNT: begin
               if (grant) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase

         if (grant) begin
            last_owner_q      <= owner;
            order_q[wr_ptr_q] <= owner;
            wr_ptr_q          <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);

         case ({grant, pop})
            2'b10:   count_q <= count_q + CNT_WIDTH'(1);
            2'b01:   count_q <= count_q - CNT_WIDTH'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_riscy_mem_port_arbiter.sv
// Directed bench for riscy_mem_port_arbiter: RR instance (u_rr) plus fixed-priority instance (u_fp)
// driven by the same stimulus.
module tb_riscy_mem_port_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   logic        a_instr_gnt, a_instr_rvalid, a_data_gnt, a_data_rvalid;
   logic [31:0] a_instr_rdata, a_data_rdata, a_mem_addr, a_mem_wdata;
   logic        a_mem_req, a_mem_we, a_spurious, a_busy;
   logic [3:0]  a_mem_be;

   logic        b_instr_gnt, b_instr_rvalid, b_data_gnt, b_data_rvalid;
   logic [31:0] b_instr_rdata, b_data_rdata, b_mem_addr, b_mem_wdata;
   logic        b_mem_req, b_mem_we, b_spurious, b_busy;
   logic [3:0]  b_mem_be;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk_i = ~clk_i;

   riscy_mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .RR_EN(1'b1)) u_rr (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(a_instr_gnt),
      .instr_rvalid_o(a_instr_rvalid), .instr_rdata_o(a_instr_rdata),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
      .data_wdata_i(data_wdata_i), .data_gnt_o(a_data_gnt), .data_rvalid_o(a_data_rvalid),
      .data_rdata_o(a_data_rdata),
      .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_be_o(a_mem_be), .mem_addr_o(a_mem_addr),
      .mem_wdata_o(a_mem_wdata), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .spurious_o(a_spurious), .busy_o(a_busy)
   );

   riscy_mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .RR_EN(1'b0)) u_fp (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(b_instr_gnt),
      .instr_rvalid_o(b_instr_rvalid), .instr_rdata_o(b_instr_rdata),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
      .data_wdata_i(data_wdata_i), .data_gnt_o(b_data_gnt), .data_rvalid_o(b_data_rvalid),
      .data_rdata_o(b_data_rdata),
      .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_be_o(b_mem_be), .mem_addr_o(b_mem_addr),
      .mem_wdata_o(b_mem_wdata), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .spurious_o(b_spurious), .busy_o(b_busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Inputs change on the falling edge; checks run 1ns later, well before the next rising edge
   task automatic next_cycle();
      @(negedge clk_i);
   endtask

   task automatic idle_inputs();
      instr_req_i  = 1'b0;
      instr_addr_i = '0;
      data_req_i   = 1'b0;
      data_we_i    = 1'b0;
      data_be_i    = '0;
      data_addr_i  = '0;
      data_wdata_i = '0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
   endtask

   initial begin
      idle_inputs();
      rst_ni       = 1'b0;
      instr_req_i  = 1'b1;
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h1234_5678;
      #1;
      chk("rst_mem_req",   64'(a_mem_req), 64'd0);
      chk("rst_instr_gnt", 64'(a_instr_gnt), 64'd0);
      chk("rst_rdata",     64'(a_instr_rdata), 64'd0);
      chk("rst_mem_be",    64'(a_mem_be), 64'd0);
      chk("rst_spurious",  64'(a_spurious), 64'd0);
      chk("rst_busy",      64'(a_busy), 64'd0);

      next_cycle();
      idle_inputs();
      rst_ni = 1'b1;

      // 1: fetch with same-cycle grant, response one cycle later
      next_cycle();
      instr_req_i = 1'b1; instr_addr_i = 32'h80; mem_gnt_i = 1'b1;
      #1;
      chk("t1_instr_gnt", 64'(a_instr_gnt), 64'd1);
      chk("t1_data_gnt",  64'(a_data_gnt), 64'd0);
      chk("t1_mem_addr",  64'(a_mem_addr), 64'h80);
      chk("t1_mem_be",    64'(a_mem_be), 64'hf);
      chk("t1_mem_we",    64'(a_mem_we), 64'd0);
      next_cycle();
      idle_inputs();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0513;
      #1;
      chk("t1_instr_rvalid", 64'(a_instr_rvalid), 64'd1);
      chk("t1_data_rvalid",  64'(a_data_rvalid), 64'd0);
      chk("t1_instr_rdata",  64'(a_instr_rdata), 64'h513);
      chk("t1_busy",         64'(a_busy), 64'd1);
      next_cycle();
      idle_inputs();
      #1;
      chk("t1_idle_busy", 64'(a_busy), 64'd0);

      // 2: tie arbitration; last owner is instr so RR starts with data
      for (int c = 0; c < 4; c++) begin
         next_cycle();
         instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
         mem_rvalid_i = (c != 0);
         #1;
         chk($sformatf("t2_rr_data_gnt%0d", c),  64'(a_data_gnt),  64'((c % 2) == 0));
         chk($sformatf("t2_rr_instr_gnt%0d", c), 64'(a_instr_gnt), 64'((c % 2) == 1));
         chk($sformatf("t2_fp_data_gnt%0d", c),  64'(b_data_gnt),  64'd1);
         chk($sformatf("t2_fp_instr_gnt%0d", c), 64'(b_instr_gnt), 64'd0);
      end
      next_cycle();
      idle_inputs();
      mem_rvalid_i = 1'b1;
      #1;
      chk("t2_rr_last_rvalid", 64'(a_instr_rvalid), 64'd1);
      chk("t2_fp_last_rvalid", 64'(b_data_rvalid), 64'd1);

      // 3: data write held through 3 cycles of grant stall; instr must not preempt
      for (int c = 0; c < 4; c++) begin
         next_cycle();
         idle_inputs();
         data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011;
         data_addr_i = 32'h100; data_wdata_i = 32'hDEAD_BEEF;
         instr_req_i = (c >= 1); instr_addr_i = 32'h200;
         mem_gnt_i = (c == 3);
         #1;
         chk($sformatf("t3_mem_addr%0d", c),  64'(a_mem_addr), 64'h100);
         chk($sformatf("t3_mem_wdata%0d", c), 64'(a_mem_wdata), 64'hDEAD_BEEF);
         chk($sformatf("t3_mem_be%0d", c),    64'(a_mem_be), 64'h3);
         chk($sformatf("t3_mem_we%0d", c),    64'(a_mem_we), 64'd1);
         chk($sformatf("t3_instr_gnt%0d", c), 64'(a_instr_gnt), 64'd0);
         chk($sformatf("t3_data_gnt%0d", c),  64'(a_data_gnt), 64'(c == 3));
         if (c == 1) chk("t3_busy_locked", 64'(a_busy), 64'd1);
      end
      next_cycle();
      idle_inputs();
      mem_rvalid_i = 1'b1;
      #1;
      chk("t3_write_rvalid", 64'(a_data_rvalid), 64'd1);
      chk("t3_instr_rvalid", 64'(a_instr_rvalid), 64'd0);

      // 4: fill two outstanding, full blocks new requests even while popping
      next_cycle();
      idle_inputs();
      instr_req_i = 1'b1; instr_addr_i = 32'h300; mem_gnt_i = 1'b1;
      #1;
      chk("t4_instr_gnt", 64'(a_instr_gnt), 64'd1);
      next_cycle();
      idle_inputs();
      data_req_i = 1'b1; data_addr_i = 32'h400; mem_gnt_i = 1'b1;
      #1;
      chk("t4_data_gnt", 64'(a_data_gnt), 64'd1);
      next_cycle();
      idle_inputs();
      instr_req_i = 1'b1; mem_gnt_i = 1'b1;
      #1;
      chk("t4_full_req", 64'(a_mem_req), 64'd0);
      chk("t4_full_gnt", 64'(a_instr_gnt), 64'd0);
      next_cycle();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA_0001;
      #1;
      chk("t4_full_pop_req", 64'(a_mem_req), 64'd0);
      chk("t4_full_pop_gnt", 64'(a_instr_gnt), 64'd0);
      chk("t4_rv1_instr",    64'(a_instr_rvalid), 64'd1);
      chk("t4_rv1_data",     64'(a_data_rvalid), 64'd0);
      next_cycle();
      idle_inputs();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBBBB_0002;
      #1;
      chk("t4_rv2_data",  64'(a_data_rvalid), 64'd1);
      chk("t4_rv2_instr", 64'(a_instr_rvalid), 64'd0);
      chk("t4_rv2_rdata", 64'(a_data_rdata), 64'hBBBB_0002);

      // 5: response with nothing outstanding
      next_cycle();
      idle_inputs();
      mem_rvalid_i = 1'b1;
      #1;
      chk("t5_spurious",     64'(a_spurious), 64'd1);
      chk("t5_instr_rvalid", 64'(a_instr_rvalid), 64'd0);
      chk("t5_data_rvalid",  64'(a_data_rvalid), 64'd0);
      next_cycle();
      idle_inputs();
      #1;
      chk("t5_spurious_end", 64'(a_spurious), 64'd0);
      chk("t5_busy",         64'(a_busy), 64'd0);

      // 6: reset with one transaction outstanding; its late response is spurious
      next_cycle();
      instr_req_i = 1'b1; instr_addr_i = 32'h500; mem_gnt_i = 1'b1;
      #1;
      chk("t6_instr_gnt", 64'(a_instr_gnt), 64'd1);
      next_cycle();
      idle_inputs();
      rst_ni = 1'b0;
      instr_req_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D; mem_gnt_i = 1'b1;
      #1;
      chk("t6_rst_busy",    64'(a_busy), 64'd0);
      chk("t6_rst_mem_req", 64'(a_mem_req), 64'd0);
      chk("t6_rst_rdata",   64'(a_data_rdata), 64'd0);
      chk("t6_rst_addr",    64'(a_mem_addr), 64'd0);
      next_cycle();
      idle_inputs();
      rst_ni = 1'b1;
      next_cycle();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BAD_0BAD;
      #1;
      chk("t6_spurious",     64'(a_spurious), 64'd1);
      chk("t6_instr_rvalid", 64'(a_instr_rvalid), 64'd0);
      chk("t6_busy",         64'(a_busy), 64'd0);
      next_cycle();
      idle_inputs();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
